sar_search: RTL and testbench
=============================

# sar_search

Sequential successive-approximation search engine that drives the 4-bit magnitude comparator's `a` operand and consumes its `le`/`gr`/`eq` flags to recover the unknown value on the comparator's `b` operand. It sits on the opposite side of the comparator interface: the comparator answers, this block asks. The block issues one probe per clock, exits early on equality, and flags inconsistent comparator responses as an error.

## Interface
- `W`, 4, operand width; must match the comparator width.
- `CW`, 3, width of the probe counter; must satisfy 2^CW > W.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new search; sampled on rising edge.
- `le`  in  1  comparator flag: guess < target.
- `gr`  in  1  comparator flag: guess > target.
- `eq`  in  1  comparator flag: guess == target.
- `guess`  out  W  probe value; wire to comparator `a`. Registered.
- `busy`  out  1  high while in PROBE.
- `done`  out  1  one-cycle pulse on successful completion.
- `exact`  out  1  result was confirmed by `eq`, not inferred.
- `err`  out  1  inconsistent flags seen; sticky until `rst` or `start`.
- `result`  out  W  recovered target value; held until next `start`.
- `steps`  out  CW  number of probes used in the last search (1..W).

## Operation
- Reset value of every output is 0. The FSM returns to IDLE and the bit index is cleared. Reset mid-search aborts at that edge, and no `done` pulse is issued.
- FSM states: IDLE, PROBE, DONE, ERR.
- `start` is accepted in IDLE, DONE and ERR, and ignored in PROBE.
  - On acceptance: `guess` = 1<<(W-1), index = W-1, `steps` = 0.
  - `err`, `exact` and `done` are cleared.
  - The FSM enters PROBE.
- In PROBE, each edge samples the flags for the current `guess` and increments `steps`:
  - Flags not exactly one-hot (000, or two or more set): go to ERR and set `err`. `guess`, `result` and `steps` freeze.
  - `eq`: `result` = `guess`, `exact` = 1, go to DONE.
  - `gr`:
    - Clear bit[index] of the trial.
    - If index > 0: set bit[index-1], decrement index, stay in PROBE.
    - If index == 0: `result` = trial with bit0 cleared, `exact` = 0, go to DONE.
  - `le`:
    - If index > 0: keep bit[index], set bit[index-1], decrement index, stay in PROBE.
    - If index == 0: go to ERR. The target cannot exceed the final trial.
- DONE lasts exactly one cycle with `done` = 1, then goes to IDLE. `result`, `exact` and `steps` hold.
- ERR holds `err` = 1 until `start` or `rst`.
- `guess` holds its last value in IDLE, DONE and ERR.
- All arithmetic is unsigned W-bit with no wrap. `steps` never exceeds W.

## Timing
- The comparator is combinational. Flags for `guess` are valid in the same cycle and are sampled at the next edge.
- `start` is sampled at edge t:
  - `busy` and the first probe are visible in cycle t+1.
  - The k-th probe's flags are sampled at edge t+k.
- Completion at the n-th probe (n in 1..W): the edge t+n moves the FSM to DONE.
  - `done` is high for one cycle after edge t+n.
  - `busy` is low from edge t+n onward.
- Worst-case latency from `start` to `done` is W+1 edges, i.e. 5 for W=4.
- `start` held high continuously restarts the search on every edge where the FSM is in IDLE, DONE or ERR.
- `rst` and `start` asserted on the same edge: `rst` wins.

## Test plan
- Target 11, comparator in loop, `start` pulse:
  - Probes are 8(le), 12(gr), 10(le), 11(eq).
  - Expect `result`=11, `exact`=1, `steps`=4, and `done` one cycle after the 4th sample edge.
- Target 8: first probe 8 returns `eq`. Expect `done` after 1 probe, `steps`=1, `exact`=1.
- Target 0:
  - Probes are 8, 4, 2, 1, all `gr`.
  - Expect `result`=0, `exact`=0, `steps`=4.
- Target 15, plus `start` re-pulsed during PROBE:
  - Probes are 8, 12, 14, 15(eq); the mid-search `start` is ignored.
  - Expect `result`=15 and `steps`=4.
- Flags forced to 000 on the 2nd probe:
  - Expect `err`=1 and no `done`.
  - A following `start` clears `err` and a fresh search for target 5 returns 5.
- `rst` asserted on the 3rd probe edge:
  - All outputs are 0 on the next cycle, with no `done`.
  - `start` after release completes normally.

Source files
------------

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : sar_search
//  Purpose  : Successive-approximation search engine. Drives a magnitude
//             comparator's `a` operand with one probe per clock and consumes
//             its le/gr/eq flags to recover the unknown `b` operand. Exits
//             early on equality and flags inconsistent responses.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             start           - request a new search (ignored while busy)
//             le, gr, eq      - comparator flags for the current guess
//             guess           - registered probe value (to comparator `a`)
//             busy            - high while probing
//             done            - one-cycle completion pulse
//             exact           - result confirmed by eq rather than inferred
//             err             - sticky inconsistent-flag indication
//             result          - recovered target value
//             steps           - probes used in the last search
//  Revision : 1.0 - initial release
// ============================================================================
module sar_search #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          le,
  input  logic          gr,
  input  logic          eq,
  output logic [W-1:0]  guess,
  output logic          busy,
  output logic          done,
  output logic          exact,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [CW-1:0] steps
);

  localparam int           IW     = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] C_MSB  = C_ONE << (W-1);
  localparam logic [IW-1:0] C_TOP = IW'(W-1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2,
    S_ERR   = 2'd3
  } state_t;

  state_t        r_state;
  logic [IW-1:0] r_index;

  logic [W-1:0]  w_bit;
  logic [W-1:0]  w_next_bit;
  logic          w_onehot;

  // Bit currently under trial and the next lower bit to try.
  assign w_bit      = C_ONE << r_index;
  assign w_next_bit = w_bit >> 1;

  // Exactly one flag set: odd parity excludes 000/two-set, and the AND
  // term excludes the all-three case.
  assign w_onehot = (le ^ gr ^ eq) & ~(le & gr & eq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_index <= '0;
      guess   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      exact   <= 1'b0;
      err     <= 1'b0;
      result  <= '0;
      steps   <= '0;
    end else begin
      case (r_state)
        S_PROBE: begin
          if (!w_onehot) begin
            // Inconsistent comparator: freeze guess/result/steps.
            err     <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_ERR;
          end else begin
            steps <= steps + CW'(1);
            if (eq) begin
              result  <= guess;
              exact   <= 1'b1;
              done    <= 1'b1;
              busy    <= 1'b0;
              r_state <= S_DONE;
            end else if (gr) begin
              if (r_index != '0) begin
                guess   <= (guess & ~w_bit) | w_next_bit;
                r_index <= r_index - IW'(1);
              end else begin
                // Target is below the final trial: it must be trial-1.
                result  <= guess & ~w_bit;
                exact   <= 1'b0;
                done    <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_DONE;
              end
            end else begin
              if (r_index != '0) begin
                guess   <= guess | w_next_bit;
                r_index <= r_index - IW'(1);
              end else begin
                // Target above the final trial is impossible.
                err     <= 1'b1;
                busy    <= 1'b0;
                r_state <= S_ERR;
              end
            end
          end
        end

        default: begin
          // IDLE, DONE and ERR all accept a new request.
          if (start) begin
            guess   <= C_MSB;
            r_index <= C_TOP;
            steps   <= '0;
            err     <= 1'b0;
            exact   <= 1'b0;
            done    <= 1'b0;
            busy    <= 1'b1;
            r_state <= S_PROBE;
          end else begin
            done <= 1'b0;
            if (r_state == S_DONE) begin
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sar_search.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sar_search
//  Purpose  : Self-checking bench for sar_search with a behavioural
//             comparator in the loop and a queue of expected outcomes.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sar_search;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       le, gr, eq;
  logic [3:0] guess;
  logic       busy, done, exact, err;
  logic [3:0] result;
  logic [2:0] steps;

  logic [3:0] target;
  logic       force_zero;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [3:0] result;
    logic       exact;
    logic [2:0] steps;
    logic       is_err;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sar_search #(.W(4), .CW(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .le     (le),
    .gr     (gr),
    .eq     (eq),
    .guess  (guess),
    .busy   (busy),
    .done   (done),
    .exact  (exact),
    .err    (err),
    .result (result),
    .steps  (steps)
  );

  // Combinational comparator model; force_zero injects a 000 response.
  always_comb begin
    le = 1'b0;
    gr = 1'b0;
    eq = 1'b0;
    if (!force_zero) begin
      le = (guess < target);
      gr = (guess > target);
      eq = (guess == target);
    end
  end

  task automatic check_val(input string tag, input logic [31:0] act,
                           input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Launch one search. force_at/restart_at/rst_at name the probe edge
  // (1-based after the start edge) at which the disturbance is sampled.
  task automatic run(input logic [3:0] tgt, input exp_t e,
                     input int force_at, input int restart_at,
                     input int rst_at);
    exp_t got;
    bit   finished;
    target = tgt;
    start  = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    start = 1'b0;
    check_val("first_guess", guess, 8);
    check_val("busy_on", busy, 1);
    check_val("err_clr", err, 0);
    finished = 0;
    for (int k = 1; k <= 8 && !finished; k++) begin
      if (k == force_at)   force_zero = 1'b1;
      if (k == restart_at) start = 1'b1;
      if (k == rst_at)     rst = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      if (k == rst_at) begin
        got = sb.pop_front();
        check_val("rst_outs", {guess, busy, done, exact, err, result, steps}, 0);
        rst = 1'b0;
        finished = 1;
      end else if (done) begin
        got = sb.pop_front();
        check_val("result", result, got.result);
        check_val("exact", exact, got.exact);
        check_val("steps", steps, got.steps);
        check_val("latency", k, got.steps);
        check_val("err_on_done", err, got.is_err);
        check_val("busy_off", busy, 0);
        finished = 1;
        @(posedge clk); #1;
        check_val("done_pulse", done, 0);
        check_val("result_hold", result, got.result);
      end else if (err) begin
        got = sb.pop_front();
        force_zero = 1'b0;
        check_val("err_exp", err, got.is_err);
        check_val("err_steps", steps, got.steps);
        check_val("err_busy", busy, 0);
        finished = 1;
        @(posedge clk); #1;
        check_val("err_sticky", err, 1);
        check_val("err_nodone", done, 0);
      end
    end
    force_zero = 1'b0;
    if (!finished) begin
      check_val("timeout", 1, 0);
      if (sb.size() > 0) got = sb.pop_front();
    end
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    target     = 4'd0;
    force_zero = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outs", {guess, busy, done, exact, err, result, steps}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(4'd11, '{result: 4'd11, exact: 1'b1, steps: 3'd4, is_err: 1'b0}, 0, 0, 0);
    run(4'd8,  '{result: 4'd8,  exact: 1'b1, steps: 3'd1, is_err: 1'b0}, 0, 0, 0);
    run(4'd0,  '{result: 4'd0,  exact: 1'b0, steps: 3'd4, is_err: 1'b0}, 0, 0, 0);
    run(4'd15, '{result: 4'd15, exact: 1'b1, steps: 3'd4, is_err: 1'b0}, 0, 2, 0);
    run(4'd5,  '{result: 4'd0,  exact: 1'b0, steps: 3'd1, is_err: 1'b1}, 2, 0, 0);
    run(4'd5,  '{result: 4'd5,  exact: 1'b1, steps: 3'd4, is_err: 1'b0}, 0, 0, 0);
    run(4'd11, '{result: 4'd0,  exact: 1'b0, steps: 3'd0, is_err: 1'b0}, 0, 0, 3);
    run(4'd11, '{result: 4'd11, exact: 1'b1, steps: 3'd4, is_err: 1'b0}, 0, 0, 0);

    check_val("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
